// File: rtl/pe2_issue_ctrl.sv
// Operand-issue front end for pe2.
// Accepts operand bundles over a valid/ready stream, drives the pe2 input
// port one cycle later, tracks in-flight U/V and Karatsuba-M results from the
// pe2 return valids, and applies credit back-pressure. A request for a new
// mode while results are outstanding drains the pipeline first, so pe2 never
// holds beats of two different modes.
//
// Mode encoding on s_mode_i / ctrl_o (2 bits):
//   0 = NTT, 1 = INTT, 2 = CWM (Karatsuba, produces M results), 3 = ADDSUB
module pe2_issue_ctrl #(
  parameter int COEFF_W      = 12,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  // upstream bundle stream
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [COEFF_W-1:0] s_a_i,
  input  logic [COEFF_W-1:0] s_b_i,
  input  logic [COEFF_W-1:0] s_w1_i,
  input  logic [COEFF_W-1:0] s_w2_i,
  input  logic [1:0]         s_mode_i,
  // pe2 input port
  output logic [COEFF_W-1:0] a2_o,
  output logic [COEFF_W-1:0] b2_o,
  output logic [COEFF_W-1:0] w1_o,
  output logic [COEFF_W-1:0] w2_o,
  output logic [1:0]         ctrl_o,
  output logic               valid_o,
  // pe2 result retire strobes
  input  logic               pe_valid_i,
  input  logic               pe_valid_m_i,
  // status
  output logic [CNT_W-1:0]   uv_inflight_o,
  output logic [CNT_W-1:0]   m_inflight_o,
  output logic               idle_o,
  output logic               err_o
);

  localparam logic [1:0] PE_MODE_NTT    = 2'd0;
  localparam logic [1:0] PE_MODE_INTT   = 2'd1;
  localparam logic [1:0] PE_MODE_CWM    = 2'd2;
  localparam logic [1:0] PE_MODE_ADDSUB = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e             state_q;
  state_e             state_n;
  logic [1:0]         cur_mode;
  logic [CNT_W-1:0]   uv_cnt;
  logic [CNT_W-1:0]   m_cnt;
  logic               err_q;

  logic               cnt_zero;
  logic               pipe_empty;
  logic               mode_match;
  logic               uv_full;
  logic               m_full;
  logic               issue;
  logic               issue_m;

  // Counter update: an issue and a retire in the same cycle cancel out; a
  // retire against an empty counter leaves it at zero (flagged separately).
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             ret);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !ret) begin
      res = cnt + CNT_W'(1);
    end else if (!inc && ret && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  // Status terms derived from registered state only (except mode_match).
  assign cnt_zero   = (uv_cnt == '0) && (m_cnt == '0);
  assign pipe_empty = cnt_zero && !valid_o;
  assign mode_match = (s_mode_i == cur_mode);
  assign uv_full    = (uv_cnt >= MAX_CNT);
  assign m_full     = (m_cnt >= MAX_CNT);
  assign issue      = s_valid_i && s_ready_o;
  assign issue_m    = issue && (s_mode_i == PE_MODE_CWM);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and upstream ready: a mode change with work outstanding
  // parks the bundle and drains; an empty pipeline switches mode in place.
  always_comb begin
    state_n   = state_q;
    s_ready_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        s_ready_o = rst_n && !uv_full && !m_full && (mode_match || pipe_empty);
        if (s_valid_i && !mode_match && !pipe_empty) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase
  end

  // ---- stage p0 -> pe2 port: register accepted bundle for exactly one cycle
  // Issue register: data is zeroed on idle cycles, mode register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      a2_o     <= '0;
      b2_o     <= '0;
      w1_o     <= '0;
      w2_o     <= '0;
      cur_mode <= PE_MODE_NTT;
    end else begin
      valid_o <= issue;
      if (issue) begin
        a2_o     <= s_a_i;
        b2_o     <= s_b_i;
        w1_o     <= s_w1_i;
        w2_o     <= s_w2_i;
        cur_mode <= s_mode_i;
      end else begin
        a2_o <= '0;
        b2_o <= '0;
        w1_o <= '0;
        w2_o <= '0;
      end
    end
  end

  // In-flight credit counters for U/V and M results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uv_cnt <= '0;
      m_cnt  <= '0;
    end else begin
      uv_cnt <= next_count(uv_cnt, issue, pe_valid_i);
      m_cnt  <= next_count(m_cnt, issue_m, pe_valid_m_i);
    end
  end

  // Sticky error on a retire strobe with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((pe_valid_i && (uv_cnt == '0)) || (pe_valid_m_i && (m_cnt == '0))) begin
      err_q <= 1'b1;
    end
  end

  assign ctrl_o        = cur_mode;
  assign uv_inflight_o = uv_cnt;
  assign m_inflight_o  = m_cnt;
  assign idle_o        = pipe_empty;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pe2_issue_ctrl.sv
// Self-checking bench for pe2_issue_ctrl: a vector table for the basic flow,
// hand-written multi-cycle corner cases, and a randomized run against a
// behavioural model of the issue/credit/drain rules.
module tb_pe2_issue_ctrl;

  localparam int COEFF_W = 12;
  localparam int MAXF    = 8;
  localparam int CNT_W   = $clog2(MAXF + 1);

  localparam logic [1:0] NTT    = 2'd0;
  localparam logic [1:0] INTT   = 2'd1;
  localparam logic [1:0] CWM    = 2'd2;
  localparam logic [1:0] ADDSUB = 2'd3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid_i;
  logic               s_ready_o;
  logic [COEFF_W-1:0] s_a_i, s_b_i, s_w1_i, s_w2_i;
  logic [1:0]         s_mode_i;
  logic [COEFF_W-1:0] a2_o, b2_o, w1_o, w2_o;
  logic [1:0]         ctrl_o;
  logic               valid_o;
  logic               pe_valid_i, pe_valid_m_i;
  logic [CNT_W-1:0]   uv_inflight_o, m_inflight_o;
  logic               idle_o, err_o;

  int n_chk  = 0;
  int n_fail = 0;

  pe2_issue_ctrl #(.COEFF_W(COEFF_W), .MAX_INFLIGHT(MAXF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_a_i(s_a_i), .s_b_i(s_b_i), .s_w1_i(s_w1_i), .s_w2_i(s_w2_i),
    .s_mode_i(s_mode_i),
    .a2_o(a2_o), .b2_o(b2_o), .w1_o(w1_o), .w2_o(w2_o),
    .ctrl_o(ctrl_o), .valid_o(valid_o),
    .pe_valid_i(pe_valid_i), .pe_valid_m_i(pe_valid_m_i),
    .uv_inflight_o(uv_inflight_o), .m_inflight_o(m_inflight_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [1:0]  md;
    logic [11:0] a, b, w1, w2;
    logic        pv, pvm;
    logic        e_rdy;
    logic        e_vld;
    logic [11:0] e_a2;
    logic [1:0]  e_ctrl;
    int          e_uv, e_m;
    logic        e_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [1:0] md, input logic [11:0] a,
                       input logic [11:0] b, input logic [11:0] w1, input logic [11:0] w2,
                       input logic pv, input logic pvm);
    s_valid_i = sv; s_mode_i = md;
    s_a_i = a; s_b_i = b; s_w1_i = w1; s_w2_i = w2;
    pe_valid_i = pv; pe_valid_m_i = pvm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, NTT, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model state (counts of results issued but not yet retired).
  int         m_uv, m_m, m_wait_zero;
  logic       m_err, m_vld, m_drain;
  logic [1:0] m_mode;
  logic [11:0] m_a2, m_b2, m_w1, m_w2;

  function automatic logic model_ready();
    logic empty;
    empty = (m_uv == 0) && (m_m == 0) && !m_vld;
    return !m_drain && (m_uv < MAXF) && (m_m < MAXF) && ((s_mode_i == m_mode) || empty);
  endfunction

  task automatic model_step(input logic rdy);
    logic iss, empty;
    empty = (m_uv == 0) && (m_m == 0) && !m_vld;
    iss   = s_valid_i && rdy;
    // drain: entered by a mode request while work is outstanding, left
    // one cycle after both counts have been observed at zero
    if (!m_drain) begin
      m_drain = s_valid_i && (s_mode_i != m_mode) && !empty;
    end else if (m_uv == 0 && m_m == 0) begin
      m_drain = 1'b0;
    end
    if (pe_valid_i && m_uv == 0) m_err = 1'b1;
    if (pe_valid_m_i && m_m == 0) m_err = 1'b1;
    if (iss && !pe_valid_i) m_uv = m_uv + 1;
    else if (!iss && pe_valid_i && m_uv > 0) m_uv = m_uv - 1;
    if (iss && s_mode_i == CWM) begin
      if (!pe_valid_m_i) m_m = m_m + 1;
    end else if (pe_valid_m_i && m_m > 0) begin
      m_m = m_m - 1;
    end
    m_vld = iss;
    m_a2 = iss ? s_a_i : 12'd0;
    m_b2 = iss ? s_b_i : 12'd0;
    m_w1 = iss ? s_w1_i : 12'd0;
    m_w2 = iss ? s_w2_i : 12'd0;
    if (iss) m_mode = s_mode_i;
  endtask

  task automatic chk_outputs_vs_model(input string tag);
    chk({tag, ".valid"}, 32'(valid_o), 32'(m_vld));
    chk({tag, ".a2"}, 32'(a2_o), 32'(m_a2));
    chk({tag, ".b2"}, 32'(b2_o), 32'(m_b2));
    chk({tag, ".w1"}, 32'(w1_o), 32'(m_w1));
    chk({tag, ".w2"}, 32'(w2_o), 32'(m_w2));
    chk({tag, ".ctrl"}, 32'(ctrl_o), 32'(m_mode));
    chk({tag, ".uv"}, 32'(uv_inflight_o), m_uv);
    chk({tag, ".m"}, 32'(m_inflight_o), m_m);
    chk({tag, ".err"}, 32'(err_o), 32'(m_err));
    chk({tag, ".idle"}, 32'(idle_o), 32'((m_uv == 0) && (m_m == 0) && !m_vld));
  endtask

  vec_t vt[16];

  initial begin
    rst_n = 1'b0;
    drive(1'b0, NTT, 12'd0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);
    #2;
    // reset state while rst_n is low
    chk("rst.ready", 32'(s_ready_o), 0);
    chk("rst.valid", 32'(valid_o), 0);
    chk("rst.ctrl", 32'(ctrl_o), 32'(NTT));
    chk("rst.uv", 32'(uv_inflight_o), 0);
    chk("rst.idle", 32'(idle_o), 1);
    chk("rst.err", 32'(err_o), 0);
    do_reset();

    // ---------------- table-driven flow ----------------
    //        sv  md    a    b    w1    w2  pv pvm  rdy vld a2  ctrl  uv m err
    vt[0]  = '{1, NTT, 10,  2, 999,   5, 0, 0,   1,  1, 10, NTT,   1, 0, 0};
    vt[1]  = '{1, NTT, 11,  3, 998,   6, 0, 0,   1,  1, 11, NTT,   2, 0, 0};
    vt[2]  = '{1, NTT, 12,  4, 997,   7, 0, 0,   1,  1, 12, NTT,   3, 0, 0};
    vt[3]  = '{1, NTT, 13,  5, 996,   8, 0, 0,   1,  1, 13, NTT,   4, 0, 0};
    vt[4]  = '{0, NTT,  0,  0,   0,   0, 1, 0,   1,  0,  0, NTT,   3, 0, 0};
    vt[5]  = '{0, NTT,  0,  0,   0,   0, 1, 0,   1,  0,  0, NTT,   2, 0, 0};
    vt[6]  = '{0, NTT,  0,  0,   0,   0, 1, 0,   1,  0,  0, NTT,   1, 0, 0};
    vt[7]  = '{0, NTT,  0,  0,   0,   0, 1, 0,   1,  0,  0, NTT,   0, 0, 0};
    vt[8]  = '{1, CWM, 21, 22,  23,  24, 0, 0,   1,  1, 21, CWM,   1, 1, 0};
    vt[9]  = '{1, NTT, 31, 32,  33,  34, 0, 0,   0,  0,  0, CWM,   1, 1, 0};
    vt[10] = '{1, NTT, 31, 32,  33,  34, 1, 1,   0,  0,  0, CWM,   0, 0, 0};
    vt[11] = '{1, NTT, 31, 32,  33,  34, 0, 0,   0,  0,  0, CWM,   0, 0, 0};
    vt[12] = '{1, NTT, 31, 32,  33,  34, 0, 0,   1,  1, 31, NTT,   1, 0, 0};
    vt[13] = '{0, NTT,  0,  0,   0,   0, 1, 0,   1,  0,  0, NTT,   0, 0, 0};
    vt[14] = '{0, NTT,  0,  0,   0,   0, 1, 0,   1,  0,  0, NTT,   0, 0, 1};
    vt[15] = '{0, NTT,  0,  0,   0,   0, 0, 1,   1,  0,  0, NTT,   0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].sv, vt[i].md, vt[i].a, vt[i].b, vt[i].w1, vt[i].w2, vt[i].pv, vt[i].pvm);
      @(negedge clk);
      chk($sformatf("vec%0d.ready", i), 32'(s_ready_o), 32'(vt[i].e_rdy));
      tick();
      chk($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(vt[i].e_vld));
      chk($sformatf("vec%0d.a2", i), 32'(a2_o), 32'(vt[i].e_a2));
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d.b2", i), 32'(b2_o), 32'(vt[i].b));
        chk($sformatf("vec%0d.w1", i), 32'(w1_o), 32'(vt[i].w1));
        chk($sformatf("vec%0d.w2", i), 32'(w2_o), 32'(vt[i].w2));
      end
      chk($sformatf("vec%0d.ctrl", i), 32'(ctrl_o), 32'(vt[i].e_ctrl));
      chk($sformatf("vec%0d.uv", i), 32'(uv_inflight_o), vt[i].e_uv);
      chk($sformatf("vec%0d.m", i), 32'(m_inflight_o), vt[i].e_m);
      chk($sformatf("vec%0d.err", i), 32'(err_o), 32'(vt[i].e_err));
      chk($sformatf("vec%0d.idle", i), 32'(idle_o),
          32'((vt[i].e_uv == 0) && (vt[i].e_m == 0) && !vt[i].e_vld));
    end

    // ---------------- CWM x3 then ADDSUB with results outstanding ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CWM, 12'(100 + i), 12'd1, 12'd2, 12'd3, 1'b0, 1'b0);
      @(negedge clk);
      chk("cwm.ready", 32'(s_ready_o), 1);
      tick();
      chk("cwm.valid", 32'(valid_o), 1);
      chk("cwm.ctrl", 32'(ctrl_o), 32'(CWM));
    end
    chk("cwm.m3", 32'(m_inflight_o), 3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDSUB, 12'd55, 12'd66, 12'd77, 12'd88, 1'b1, 1'b1);
      @(negedge clk);
      chk("sw.ready_blocked", 32'(s_ready_o), 0);
      tick();
      chk("sw.no_issue", 32'(valid_o), 0);
      chk("sw.ctrl_hold", 32'(ctrl_o), 32'(CWM));
    end
    chk("sw.m0", 32'(m_inflight_o), 0);
    begin
      int  waited;
      logic issued, r;
      waited = 0;
      issued = 1'b0;
      drive(1'b1, ADDSUB, 12'd55, 12'd66, 12'd77, 12'd88, 1'b0, 1'b0);
      while (!issued && waited < 20) begin
        @(negedge clk);
        r = s_ready_o;
        tick();
        if (r) begin
          issued = 1'b1;
          chk("sw.valid", 32'(valid_o), 1);
          chk("sw.ctrl_new", 32'(ctrl_o), 32'(ADDSUB));
          chk("sw.a2", 32'(a2_o), 55);
        end else begin
          chk("sw.wait_valid", 32'(valid_o), 0);
          waited++;
        end
      end
      chk("sw.issued", 32'(issued), 1);
      chk("sw.gap_ge1", 32'(waited >= 1), 1);
    end

    // ---------------- back-pressure at MAX_INFLIGHT ----------------
    do_reset();
    drive(1'b1, NTT, 12'd9, 12'd8, 12'd7, 12'd6, 1'b0, 1'b0);
    for (int i = 0; i < MAXF; i++) begin
      @(negedge clk);
      chk("bp.ready", 32'(s_ready_o), 1);
      tick();
    end
    chk("bp.uv8", 32'(uv_inflight_o), 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.ninth_blocked", 32'(s_ready_o), 0);
      tick();
      chk("bp.no_valid", 32'(valid_o), 0);
    end
    pe_valid_i = 1'b1;
    @(negedge clk);
    chk("bp.ret_no_unblock", 32'(s_ready_o), 0);
    tick();
    pe_valid_i = 1'b0;
    chk("bp.uv7", 32'(uv_inflight_o), 7);
    @(negedge clk);
    chk("bp.ninth_ready", 32'(s_ready_o), 1);
    tick();
    s_valid_i = 1'b0;
    chk("bp.ninth_valid", 32'(valid_o), 1);
    chk("bp.uv8_again", 32'(uv_inflight_o), 8);

    // ---------------- simultaneous issue and retire ----------------
    do_reset();
    drive(1'b1, NTT, 12'd1, 12'd2, 12'd3, 12'd4, 1'b0, 1'b0);
    repeat (3) tick();
    chk("sim.uv3", 32'(uv_inflight_o), 3);
    pe_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sim.valid", 32'(valid_o), 1);
      chk("sim.uv_hold", 32'(uv_inflight_o), 3);
    end
    chk("sim.err", 32'(err_o), 0);

    // ---------------- asynchronous reset mid-stream ----------------
    do_reset();
    drive(1'b1, CWM, 12'd5, 12'd5, 12'd5, 12'd5, 1'b0, 1'b0);
    repeat (5) tick();
    chk("ar.uv5", 32'(uv_inflight_o), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 32'(valid_o), 0);
    chk("ar.a2", 32'(a2_o), 0);
    chk("ar.uv", 32'(uv_inflight_o), 0);
    chk("ar.m", 32'(m_inflight_o), 0);
    chk("ar.ctrl", 32'(ctrl_o), 32'(NTT));
    chk("ar.ready", 32'(s_ready_o), 0);
    chk("ar.idle", 32'(idle_o), 1);
    s_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pe_valid_i = 1'b1;
    tick();
    pe_valid_i = 1'b0;
    chk("ar.late_ret_err", 32'(err_o), 1);
    chk("ar.late_ret_uv", 32'(uv_inflight_o), 0);
    drive(1'b1, NTT, 12'd7, 12'd8, 12'd9, 12'd10, 1'b0, 1'b0);
    @(negedge clk);
    chk("ar.post_ready", 32'(s_ready_o), 1);
    tick();
    s_valid_i = 1'b0;
    chk("ar.post_valid", 32'(valid_o), 1);
    chk("ar.post_a2", 32'(a2_o), 7);
    chk("ar.post_ctrl", 32'(ctrl_o), 32'(NTT));
    chk("ar.post_uv", 32'(uv_inflight_o), 1);

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_uv = 0; m_m = 0; m_wait_zero = 0;
    m_err = 1'b0; m_vld = 1'b0; m_drain = 1'b0; m_mode = NTT;
    m_a2 = '0; m_b2 = '0; m_w1 = '0; m_w2 = '0;
    begin
      logic       held;
      logic [1:0] last_md;
      logic       r;
      held = 1'b0;
      last_md = NTT;
      for (int c = 0; c < 1500; c++) begin
        if (!held) begin
          s_valid_i = ($urandom_range(0, 9) < 7);
          if ($urandom_range(0, 9) < 2) last_md = 2'($urandom_range(0, 3));
          s_mode_i = last_md;
          s_a_i  = 12'($urandom);
          s_b_i  = 12'($urandom);
          s_w1_i = 12'($urandom);
          s_w2_i = 12'($urandom);
        end
        pe_valid_i   = (m_uv > 0) && ($urandom_range(0, 9) < 3);
        pe_valid_m_i = (m_m > 0) && ($urandom_range(0, 9) < 3);
        r = model_ready();
        @(negedge clk);
        chk("rnd.ready", 32'(s_ready_o), 32'(r));
        model_step(r);
        tick();
        chk_outputs_vs_model("rnd");
        held = s_valid_i && !r;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Overall time bound in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
